grant_owner_ctrl: RTL and testbench
===================================

// Module: grant_owner_ctrl
// PURPOSE
//  Ownership controller wrapped around the 4-bit combinational daisy-chain arbiter.
//  - Gates the raw requests into the arbiter and registers its one-hot grant as bus ownership.
//  - Holds ownership until the owner drops its request or a tenure limit expires.
//  - Inserts a turnaround gap between owners and masks a preempted owner for one round.
//  Sits between the requesters and the arbiter: feeds its r inputs and consumes its g outputs.
// PARAMETERS
//  N           4   requester count; must equal the arbiter width (4); index 0 = highest priority
//  MAX_HOLD    16  max consecutive cycles own[] may stay asserted for one owner (>=1)
//  GAP_CYCLES  1   idle cycles between release and next arbitration (>=1)
// PORTS
//  clk       in   1       single clock; all state updates on the rising edge
//  reset     in   1       synchronous, active-high reset
//  req       in   [0:N-1] raw requests, level-held by each requester
//  arb_req   out  [0:N-1] gated requests to arbiter r inputs (combinational)
//  arb_gnt   in   [0:N-1] arbiter g outputs (combinational one-hot or zero)
//  own       out  [0:N-1] registered one-hot ownership
//  busy      out  1       high whenever state != IDLE
//  preempt   out  1       1-cycle pulse on a forced release
//  hold_cnt  out  CW      cycles owned so far; CW = $clog2(MAX_HOLD+1)
//  err       out  1       sticky protocol error flag
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; own=0, busy=0, preempt=0, hold_cnt=0, err=0, mask=0, gap_cnt=0.
//    - Reset asserted mid-tenure drops own at the next edge; there is no drain.
//  FSM states: IDLE, OWN, GAP.
//  arb_req = (state==IDLE) ? (req & ~mask_eff) : 0
//    - mask_eff = mask, except when (req & ~mask)==0, then mask_eff = 0.
//    - A masked requester is therefore still served when it is the only one requesting.
//  IDLE -> OWN: when arb_gnt != 0.
//    - own <= arb_gnt, hold_cnt <= 1, mask <= 0.
//    - Latency: req sampled at edge k -> own valid after edge k+1 (1 cycle).
//  OWN (owner o = index of the set bit in own):
//    - req[o]==0 at edge: own <= 0, state <= GAP, gap_cnt <= GAP_CYCLES-1, hold_cnt <= 0.
//    - else if hold_cnt==MAX_HOLD: same as release, plus preempt <= 1 for one cycle and mask <= own.
//      Max owned cycles = MAX_HOLD.
//    - else: hold_cnt <= hold_cnt+1 (saturates at MAX_HOLD, never wraps).
//    - Changes on other req bits are ignored while in OWN.
//  GAP:
//    - own=0, arb_req=0.
//    - When gap_cnt==0: state <= IDLE; else gap_cnt <= gap_cnt-1.
//    - Requests present during GAP are arbitrated in the first IDLE cycle.
//  Simultaneous events:
//    - Release and limit in the same cycle count as a normal release; no preempt, no mask.
//    - Owner re-raising req in GAP re-arbitrates by priority like any other requester.
//  err (sticky until reset) is set in IDLE when either:
//    - arb_gnt has more than one bit set, or
//    - arb_gnt & ~arb_req != 0.
//    In both cases the grant is not captured and the FSM stays in IDLE.
//  preempt clears the cycle after it is set. busy = (state!=IDLE).
// STRUCTURE
//  Package grant_owner_pkg: state enum {IDLE, OWN, GAP}; default-parameter localparams;
//    CW width function.
//  Sub-module tenure_counter: hold_cnt with load, increment, saturate and limit-hit output.
//    Instantiated once.
//  Top level: FSM, mask register, gap counter and err logic.
//    The daisy-chain arbiter is instantiated by the parent, not inside this block.
// TESTING (bench instantiates the 4-bit arbiter plus this block; N=4, MAX_HOLD=4, GAP_CYCLES=1)
//  1. Hold reset 2 cycles with req=1111 -> own=0000, busy=0, err=0, arb_req=0000 throughout.
//  2. req=0010 at edge 0 -> own=0010 after edge 1, hold_cnt=1; drop req at edge 3
//     -> own=0000 after edge 4, one GAP cycle, IDLE.
//  3. req=1000 held -> own=1000 for exactly 4 cycles, then preempt=1 for one cycle.
//     Then with req=1100: mask=1000, so index 1 gets own=0100.
//  4. req=1000 held alone past the limit -> mask overridden, own=1000 again after the gap;
//     preempt pulses every tenure.
//  5. During OWN of index 2, raise req[0] -> own unchanged until index 2 releases,
//     then index 0 wins the next round.
//  6. Force arb_gnt=0110 in IDLE -> err=1 (sticky), no capture; assert reset mid-OWN -> own=0000 next edge.

Source files
------------

// File: rtl/grant_owner_pkg.sv
// Shared types and defaults for the bus ownership controller.
package grant_owner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DEF_N          = 4;
  localparam int DEF_MAX_HOLD   = 16;
  localparam int DEF_GAP_CYCLES = 1;

  // Width needed to count 0..max_hold inclusive.
  function automatic int cnt_width(input int max_hold);
    if (max_hold < 1) begin
      return 1;
    end else begin
      return $clog2(max_hold + 1);
    end
  endfunction

endpackage

// File: rtl/grant_owner_ctrl_tenure_counter.sv
// Tenure counter: tracks how long the current owner has held the bus.
// Loads 1 on capture, increments while owned, saturates at MAX_HOLD.
module tenure_counter
  import grant_owner_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CW       = cnt_width(DEF_MAX_HOLD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          limit_hit_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear beats load beats increment; increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CW'(1);
    end else if (inc_i && (cnt_q != CW'(MAX_HOLD))) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign limit_hit_o = (cnt_q == CW'(MAX_HOLD));

endmodule

// File: rtl/grant_owner_ctrl.sv
// Ownership controller around an external daisy-chain arbiter: gates requests,
// registers the one-hot grant as ownership, enforces a tenure limit, inserts a
// turnaround gap and masks a preempted owner for one round.
module grant_owner_ctrl
  import grant_owner_pkg::*;
#(
  parameter int  N          = DEF_N,
  parameter int  MAX_HOLD   = DEF_MAX_HOLD,
  parameter int  GAP_CYCLES = DEF_GAP_CYCLES,
  localparam int CW         = cnt_width(MAX_HOLD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:N-1]  req,
  output logic [0:N-1]  arb_req,
  input  logic [0:N-1]  arb_gnt,
  output logic [0:N-1]  own,
  output logic          busy,
  output logic          preempt,
  output logic [CW-1:0] hold_cnt,
  output logic          err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [0:N-1]  own_q, own_d;
  logic [0:N-1]  mask_q, mask_d;
  logic          preempt_q, preempt_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic [0:N-1]  mask_eff_s;
  logic          seen_s, multi_hot_s, foreign_s, grant_bad_s;
  logic          owner_req_s, limit_hit_s;
  logic          cnt_load_s, cnt_inc_s, cnt_clr_s;

  // Request gating toward the arbiter and health checks on its grant.
  always_comb begin
    if ((req & ~mask_q) == '0) begin
      mask_eff_s = '0;
    end else begin
      mask_eff_s = mask_q;
    end
    if ((state_q == IDLE) && !reset) begin
      arb_req = req & ~mask_eff_s;
    end else begin
      arb_req = '0;
    end
    seen_s      = 1'b0;
    multi_hot_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      multi_hot_s = multi_hot_s | (seen_s & arb_gnt[i]);
      seen_s      = seen_s | arb_gnt[i];
    end
    foreign_s   = |(arb_gnt & ~arb_req);
    grant_bad_s = multi_hot_s | foreign_s;
    owner_req_s = |(req & own_q);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!grant_bad_s && (arb_gnt != '0)) begin
          state_d = OWN;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!owner_req_s || limit_hit_s) begin
          state_d = GAP;
        end else begin
          state_d = OWN;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates per state: ownership, mask, gap count, preempt, err, tenure.
  always_comb begin
    own_d      = own_q;
    mask_d     = mask_q;
    preempt_d  = 1'b0;
    err_d      = err_q;
    gap_cnt_d  = gap_cnt_q;
    cnt_load_s = 1'b0;
    cnt_inc_s  = 1'b0;
    cnt_clr_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_bad_s) begin
          err_d = 1'b1;
        end else if (arb_gnt != '0) begin
          own_d      = arb_gnt;
          mask_d     = '0;
          cnt_load_s = 1'b1;
        end else begin
          own_d = '0;
        end
      end
      OWN: begin
        if (!owner_req_s) begin
          own_d     = '0;
          gap_cnt_d = GW'(GAP_CYCLES - 1);
          cnt_clr_s = 1'b1;
        end else if (limit_hit_s) begin
          own_d     = '0;
          gap_cnt_d = GW'(GAP_CYCLES - 1);
          cnt_clr_s = 1'b1;
          preempt_d = 1'b1;
          mask_d    = own_q;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      GAP: begin
        own_d = '0;
        if (gap_cnt_q == '0) begin
          gap_cnt_d = gap_cnt_q;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        own_d     = '0;
        cnt_clr_s = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      own_q     <= '0;
      mask_q    <= '0;
      preempt_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      mask_q    <= mask_d;
      preempt_q <= preempt_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  tenure_counter #(
    .MAX_HOLD (MAX_HOLD),
    .CW       (CW)
  ) u_tenure (
    .clk         (clk),
    .reset       (reset),
    .load_i      (cnt_load_s),
    .inc_i       (cnt_inc_s),
    .clr_i       (cnt_clr_s),
    .cnt_o       (hold_cnt),
    .limit_hit_o (limit_hit_s)
  );

  assign own     = own_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;
  assign err     = err_q;

endmodule

// File: tb/tb_grant_owner_ctrl.sv
// Bench for grant_owner_ctrl with a 4-bit daisy-chain arbiter in the loop.
module tb_grant_owner_ctrl;

  localparam int MAXH = 4;
  localparam int GAPC = 1;

  logic       clk;
  logic       reset;
  logic [0:3] req;
  logic [0:3] arb_req;
  logic [0:3] arb_gnt;
  logic [0:3] own;
  logic       busy;
  logic       preempt;
  logic [2:0] hold_cnt;
  logic       err;

  logic       force_en;
  logic [0:3] force_val;
  logic [0:3] chain_gnt;
  logic       blocked;

  grant_owner_ctrl #(.N(4), .MAX_HOLD(MAXH), .GAP_CYCLES(GAPC)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .arb_req  (arb_req),
    .arb_gnt  (arb_gnt),
    .own      (own),
    .busy     (busy),
    .preempt  (preempt),
    .hold_cnt (hold_cnt),
    .err      (err)
  );

  // Daisy-chain arbiter (index 0 first), with an override to inject bad grants.
  always_comb begin
    blocked = 1'b0;
    chain_gnt = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      chain_gnt[i] = arb_req[i] & ~blocked;
      blocked = blocked | arb_req[i];
    end
    arb_gnt = force_en ? force_val : chain_gnt;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (owner index / tenure / gap view) -------
  int  m_phase;   // 0 idle, 1 owned, 2 gap
  int  m_owner;   // -1 when nobody owns the bus
  int  m_tenure;
  int  m_gap;
  int  m_masked;  // index skipped next round, -1 when none
  bit  m_err;
  bit  m_pre;

  function automatic logic [0:3] onehot(input int idx);
    logic [0:3] v;
    v = 4'b0000;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:3] m_arbreq(input logic [0:3] r, input logic rst);
    logic [0:3] elig;
    if (rst || m_phase != 0) return 4'b0000;
    elig = r & ~onehot(m_masked);
    if (elig == 4'b0000) elig = r;
    return elig;
  endfunction

  function automatic int first_idx(input logic [0:3] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void m_reset();
    m_phase = 0; m_owner = -1; m_tenure = 0; m_gap = 0;
    m_masked = -1; m_err = 1'b0; m_pre = 1'b0;
  endfunction

  function automatic void m_release(input bit forced);
    if (forced) m_masked = m_owner;
    m_pre    = forced;
    m_owner  = -1;
    m_tenure = 0;
    m_gap    = GAPC - 1;
    m_phase  = 2;
  endfunction

  function automatic void model_update(input logic [0:3] r, input logic rst,
                                       input logic frc, input logic [0:3] fg);
    logic [0:3] areq, gnt;
    int ones;
    areq  = m_arbreq(r, rst);
    gnt   = frc ? fg : onehot(first_idx(areq));
    m_pre = 1'b0;
    if (rst) begin
      m_reset();
    end else if (m_phase == 0) begin
      ones = $countones(gnt);
      if (ones > 1 || (gnt & ~areq) != 4'b0000) begin
        m_err = 1'b1;
      end else if (ones == 1) begin
        m_owner = first_idx(gnt); m_tenure = 1; m_masked = -1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!r[m_owner])            m_release(1'b0);
      else if (m_tenure == MAXH)  m_release(1'b1);
      else                        m_tenure++;
    end else begin
      if (m_gap == 0) m_phase = 0;
      else            m_gap--;
    end
  endfunction

  // ---------------- scoreboard ---------------------------------------------
  typedef struct {
    logic [0:3] own;
    logic [0:3] arb_req;
    logic       busy;
    logic       preempt;
    logic       err;
    logic [2:0] hold;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("own",      32'(own),      32'(e.own));
        chk("arb_req",  32'(arb_req),  32'(e.arb_req));
        chk("busy",     32'(busy),     32'(e.busy));
        chk("preempt",  32'(preempt),  32'(e.preempt));
        chk("err",      32'(err),      32'(e.err));
        chk("hold_cnt", 32'(hold_cnt), 32'(e.hold));
      end
    end
  end

  // One cycle: drive inputs, queue what the DUT must show now, then clock.
  task automatic step(input logic [0:3] r, input logic rst = 1'b0,
                      input logic frc = 1'b0, input logic [0:3] fg = 4'b0000);
    exp_t e;
    req = r; reset = rst; force_en = frc; force_val = fg;
    e.own     = onehot(m_owner);
    e.arb_req = m_arbreq(r, rst);
    e.busy    = (m_phase != 0);
    e.preempt = m_pre;
    e.err     = m_err;
    e.hold    = 3'(m_tenure);
    sb_q.push_back(e);
    @(posedge clk);
    model_update(r, rst, frc, fg);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:3] r;
    reset = 1'b1; req = 4'b1111; force_en = 1'b0; force_val = 4'b0000;
    @(posedge clk);
    m_reset();
    #1;

    // Reset held with all requests up.
    repeat (2) step(4'b1111, 1'b1);
    // Single requester, release by dropping the request.
    repeat (3) step(4'b0010);
    repeat (4) step(4'b0000);
    // Tenure limit for index 0, then masked round with index 1 also asking.
    repeat (5) step(4'b1000);
    repeat (8) step(4'b1100);
    repeat (3) step(4'b0000);
    // Lone requester past the limit: mask is overridden, preempt every tenure.
    repeat (16) step(4'b1000);
    repeat (3) step(4'b0000);
    // Higher priority arrives mid-tenure of index 2.
    repeat (2) step(4'b0010);
    repeat (2) step(4'b1010);
    repeat (6) step(4'b1000);
    repeat (3) step(4'b0000);
    // Illegal grants in IDLE: multi-hot, then a grant nobody asked for.
    step(4'b0110, 1'b0, 1'b1, 4'b0110);
    repeat (2) step(4'b0000);
    step(4'b0100, 1'b0, 1'b1, 4'b0001);
    // Reset in the middle of a tenure.
    repeat (3) step(4'b0100);
    step(4'b0100, 1'b1);
    repeat (3) step(4'b0100);
    repeat (3) step(4'b0000);

    // Randomized traffic with occasional injected grants and resets.
    r = 4'b0000;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0)
        step(r, 1'b0, 1'b1, 4'($urandom_range(1, 15)));
      else if ($urandom_range(0, 149) == 0)
        step(r, 1'b1);
      else
        step(r);
    end
    step(4'b0000);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
